instr_mem_fetch: RTL and testbench

INSTR_MEM_FETCH -- requirements
Module: instr_mem_fetch

---
 rtl/instr_mem_fetch_pkg.sv | 29 ++
 rtl/instr_mem_fetch_imem_array.sv | 74 +++++++
 rtl/instr_mem_fetch.sv | 131 +++++++++++++
 tb/tb_instr_mem_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch_pkg
// Shared constants for the instruction fetch path and downstream pipeline
// stages: the instruction-word width and the NOP encoding returned on a bad
// fetch. Also holds a small saturating-increment helper used by error
// counters.
// -----------------------------------------------------------------------------
package instr_mem_fetch_pkg;

    // Width of one instruction word in bits.
    localparam int INSTR_W = 32;

    // All-zero word executes as a NOP; also the power-up memory content.
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    // Saturating +1 for an 8-bit-or-wider counter passed in a 32-bit container.
    // Returns cnt unchanged once it has reached max.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input logic [31:0] max);
        logic [31:0] res;
        if (cnt >= max) begin
            res = max;
        end else begin
            res = cnt + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/instr_mem_fetch_imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// DEPTH x 32 instruction storage with one synchronous write port and one
// synchronous read port. A read of the word being written in the same cycle
// returns the new data (write-first). The read-data register can be loaded
// with NOP instead of the stored word so the parent can return a clean NOP
// for rejected fetches while keeping resp_data a pure register output.
//
// Ports:
//   clk    - clock, posedge
//   rst_n  - async active-low reset; clears only the read-data register
//   we     - write strobe
//   waddr  - write word index
//   wdata  - write data
//   re     - read enable; when low the read-data register holds
//   rzero  - when re is high, load NOP instead of the addressed word
//   raddr  - read word index
//   rdata  - registered read data
// -----------------------------------------------------------------------------
module imem_array
    import instr_mem_fetch_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic               rzero,
    input  logic [IDX_W-1:0]   raddr,
    output logic [INSTR_W-1:0] rdata
);

    // Storage is intentionally not reset so program contents survive rst_n.
    logic [INSTR_W-1:0] mem_r [DEPTH];
    logic [INSTR_W-1:0] rdata_r;
    logic [INSTR_W-1:0] rdata_nxt_s;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Select the value the read register captures: NOP, bypassed write data, or stored word.
    always_comb begin
        rdata_nxt_s = rdata_r;
        if (!re) begin
            rdata_nxt_s = rdata_r;
        end else if (rzero) begin
            rdata_nxt_s = NOP;
        end else if (we && (waddr == raddr)) begin
            rdata_nxt_s = wdata;
        end else begin
            rdata_nxt_s = mem_r[raddr];
        end
    end

    // Read-data register; cleared asynchronously so the output is NOP in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= NOP;
        end else begin
            rdata_r <= rdata_nxt_s;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch
// Instruction fetch stage backed by a loadable on-chip instruction memory.
// Accepts one fetch per cycle on a valid/ready request channel and returns the
// word one cycle later on a valid/ready response channel. Misaligned or
// out-of-range fetches return NOP with resp_err set and bump a saturating
// error counter. flush drops any pending response (branch redirect).
//
// Ports:
//   clk, rst_n             - clock (posedge), async active-low reset
//   req_valid/req_ready    - fetch request handshake
//   req_addr [ADDR_W]      - fetch byte address (PC)
//   resp_valid/resp_ready  - response handshake
//   resp_data [32]         - fetched instruction (NOP on error)
//   resp_err               - fetch was misaligned or out of range
//   flush                  - discard pending response, block acceptance
//   ld_en/ld_addr/ld_data  - program-load write port (word indexed)
//   err_cnt [ERR_CNT_W]    - saturating count of erroneous fetches
// -----------------------------------------------------------------------------
module instr_mem_fetch
    import instr_mem_fetch_pkg::*;
#(
    parameter int DEPTH     = 128,
    parameter int ADDR_W    = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [INSTR_W-1:0]       resp_data,
    output logic                     resp_err,
    input  logic                     flush,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [INSTR_W-1:0]       ld_data,
    output logic [ERR_CNT_W-1:0]     err_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    logic                 resp_valid_r;
    logic                 resp_err_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    logic                 req_ready_s;
    logic                 accept_s;
    logic                 addr_err_s;
    logic                 ld_we_s;
    logic [IDX_W-1:0]     fetch_idx_s;
    logic                 resp_valid_nxt_s;
    logic                 resp_err_nxt_s;
    logic [ERR_CNT_W-1:0] err_cnt_nxt_s;
    logic [31:0]          err_cnt_inc_s;

    // Handshake and address decode; out-of-range means any byte-address bit above the array span is set.
    always_comb begin
        req_ready_s = !flush && (!resp_valid_r || resp_ready);
        accept_s    = req_valid && req_ready_s;
        fetch_idx_s = req_addr[IDX_W+1:2];
        if ((req_addr[1:0] != 2'b00) || (req_addr[ADDR_W-1:IDX_W+2] != '0)) begin
            addr_err_s = 1'b1;
        end else begin
            addr_err_s = 1'b0;
        end
        // Loads are blocked while reset is asserted.
        ld_we_s = ld_en && rst_n;
    end

    // Next-state for the response register and the error counter.
    always_comb begin
        resp_valid_nxt_s = resp_valid_r;
        resp_err_nxt_s   = resp_err_r;
        err_cnt_nxt_s    = err_cnt_r;
        err_cnt_inc_s    = sat_inc(32'(err_cnt_r), 32'(ERR_MAX));
        if (flush) begin
            resp_valid_nxt_s = 1'b0;
        end else if (accept_s) begin
            resp_valid_nxt_s = 1'b1;
            resp_err_nxt_s   = addr_err_s;
        end else if (resp_ready) begin
            resp_valid_nxt_s = 1'b0;
        end else begin
            resp_valid_nxt_s = resp_valid_r;
        end
        if (accept_s && addr_err_s) begin
            err_cnt_nxt_s = err_cnt_inc_s[ERR_CNT_W-1:0];
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end
    end

    // Response-control and error-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            err_cnt_r    <= '0;
        end else begin
            resp_valid_r <= resp_valid_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
            err_cnt_r    <= err_cnt_nxt_s;
        end
    end

    // Storage; the read register only moves on acceptance, which keeps resp_data stable during a stall.
    imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_imem_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ld_we_s),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (accept_s),
        .rzero (addr_err_s),
        .raddr (fetch_idx_s),
        .rdata (resp_data)
    );

    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_fetch
// Directed self-checking bench for instr_mem_fetch (DEPTH=128, ERR_CNT_W=8).
// -----------------------------------------------------------------------------
module tb_instr_mem_fetch;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        flush;
    logic        ld_en;
    logic [6:0]  ld_addr;
    logic [31:0] ld_data;
    logic [7:0]  err_cnt;

    int n_vec;
    int n_err;

    instr_mem_fetch #(
        .DEPTH     (128),
        .ADDR_W    (32),
        .ERR_CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .flush      (flush),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .err_cnt    (err_cnt)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] held;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        resp_ready = 1'b1;
        flush      = 1'b0;
        ld_en      = 1'b0;
        ld_addr    = 7'd0;
        ld_data    = 32'h0;

        // Reset state
        step();
        step();
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_data",  resp_data, 32'h0);
        chk("rst_err",   {31'd0, resp_err}, 32'd0);
        chk("rst_cnt",   {24'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;

        // Program load of two words
        ld_en = 1'b1; ld_addr = 7'd0; ld_data = 32'h8C10_0000;
        step();
        ld_addr = 7'd1; ld_data = 32'h8C11_0004;
        step();
        ld_en = 1'b0;

        // Back-to-back fetches of addresses 0 and 4
        req_valid = 1'b1; req_addr = 32'h0; resp_ready = 1'b1;
        #1;
        chk("b2b_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("b2b0_valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b0_data",  resp_data, 32'h8C10_0000);
        chk("b2b0_err",   {31'd0, resp_err}, 32'd0);
        req_addr = 32'h4;
        step();
        chk("b2b1_valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b1_data",  resp_data, 32'h8C11_0004);
        chk("b2b1_err",   {31'd0, resp_err}, 32'd0);
        req_valid = 1'b0;
        step();
        chk("drain_valid", {31'd0, resp_valid}, 32'd0);

        // Misaligned then out-of-range fetch
        req_valid = 1'b1; req_addr = 32'h2;
        step();
        chk("mis_data", resp_data, 32'h0);
        chk("mis_err",  {31'd0, resp_err}, 32'd1);
        chk("mis_cnt",  {24'd0, err_cnt}, 32'd1);
        req_addr = 32'h200;
        step();
        chk("oor_valid", {31'd0, resp_valid}, 32'd1);
        chk("oor_err",   {31'd0, resp_err}, 32'd1);
        chk("oor_data",  resp_data, 32'h0);
        chk("oor_cnt",   {24'd0, err_cnt}, 32'd2);
        req_addr = 32'h1FC;
        step();
        chk("last_word_err", {31'd0, resp_err}, 32'd0);
        req_valid = 1'b0;
        step();

        // Stall: response held for 3 cycles, then the next fetch goes through
        req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b0;
        step();
        chk("stall_data0", resp_data, 32'h8C11_0004);
        held = resp_data;
        req_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", {31'd0, req_ready}, 32'd0);
            step();
            chk("stall_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall_data",  resp_data, held);
        end
        resp_ready = 1'b1;
        #1;
        chk("release_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("release_data",  resp_data, 32'h8C10_0000);
        chk("release_valid", {31'd0, resp_valid}, 32'd1);

        // Flush while a response is valid
        req_addr = 32'h4; flush = 1'b1;
        #1;
        chk("flush_ready", {31'd0, req_ready}, 32'd0);
        step();
        chk("flush_valid", {31'd0, resp_valid}, 32'd0);
        chk("flush_cnt",   {24'd0, err_cnt}, 32'd2);
        flush = 1'b0; req_valid = 1'b0;
        step();

        // Load and fetch of the same word in one cycle
        ld_en = 1'b1; ld_addr = 7'd5; ld_data = 32'h0800_0003;
        req_valid = 1'b1; req_addr = 32'h14;
        step();
        chk("wf_data", resp_data, 32'h0800_0003);
        chk("wf_err",  {31'd0, resp_err}, 32'd0);
        ld_en = 1'b0;
        req_addr = 32'h0;
        step();
        chk("after_wf_data", resp_data, 32'h8C10_0000);
        req_addr = 32'h14;
        step();
        chk("stored_data", resp_data, 32'h0800_0003);
        req_valid = 1'b0;
        step();

        // 300 erroneous fetches: counter saturates
        req_valid = 1'b1; req_addr = 32'h1;
        for (int i = 0; i < 300; i++) begin
            step();
        end
        chk("sat_cnt", {24'd0, err_cnt}, 32'd255);
        req_valid = 1'b0;
        step();

        // Async reset mid-stall, load ignored during reset, memory preserved
        req_valid = 1'b1; req_addr = 32'h14; resp_ready = 1'b0;
        step();
        chk("pre_rst_data", resp_data, 32'h0800_0003);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, resp_valid}, 32'd0);
        chk("arst_data",  resp_data, 32'h0);
        chk("arst_err",   {31'd0, resp_err}, 32'd0);
        chk("arst_cnt",   {24'd0, err_cnt}, 32'd0);
        ld_en = 1'b1; ld_addr = 7'd5; ld_data = 32'hFFFF_FFFF;
        step();
        ld_en = 1'b0;
        rst_n = 1'b1;
        req_valid = 1'b1; req_addr = 32'h14; resp_ready = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("post_rst_valid", {31'd0, resp_valid}, 32'd1);
        chk("post_rst_data",  resp_data, 32'h0800_0003);
        req_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
